// File: rtl/motion_arbiter.sv
// Fixed-priority owner arbitration of the single motor-drive path with forced
// STOP dead-time on every ownership change and a tick-counted hold timeout.
module motion_arbiter #(
  parameter int unsigned DEAD_CYCLES    = 4,
  parameter int unsigned MAX_HOLD_TICKS = 10,
  parameter logic [7:0]  DUTY_MAX       = 8'd200,
  parameter bit          PREEMPT        = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tick,
  input  logic [2:0]  req,
  input  logic [5:0]  cmd_in,
  input  logic [23:0] duty_in,
  output logic [2:0]  grant,
  output logic [1:0]  motor_cmd,
  output logic [7:0]  motor_duty,
  output logic [1:0]  state,
  output logic        timeout
);

  localparam int unsigned DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES + 1) : 1;
  localparam int unsigned HW = (MAX_HOLD_TICKS > 1) ? $clog2(MAX_HOLD_TICKS + 1) : 1;
  localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD_TICKS - 1);
  localparam logic [HW-1:0] HOLD_SAT  = HW'(MAX_HOLD_TICKS);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_GAP     = 2'b01,
    ST_GRANTED = 2'b10
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    pend_q, pend_d;
  logic [2:0]    grant_q, grant_d;
  logic [2:0]    mask_q, mask_d;
  logic [DW-1:0] dead_q, dead_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [1:0]    cmd_q, cmd_d;
  logic [7:0]    duty_q, duty_d;
  logic          timeout_q, timeout_d;

  logic [2:0]    mask_eff;
  logic [2:0]    elig;
  logic [2:0]    win;
  logic [1:0]    own_cmd;
  logic [7:0]    own_duty;

  // pend/grant are one-hot, so a numerically smaller value is a higher priority
  always_comb begin
    mask_eff = mask_q & req;
    if (state_q == ST_IDLE && req != 3'b000 && (req & ~mask_eff) == 3'b000)
      mask_eff = '0;
    elig = req & ~mask_eff;
    win  = elig & (~elig + 3'd1);
  end

  always_comb begin
    own_cmd  = '0;
    own_duty = '0;
    unique case (grant_q)
      3'b001:  begin own_cmd = cmd_in[1:0]; own_duty = duty_in[7:0];   end
      3'b010:  begin own_cmd = cmd_in[3:2]; own_duty = duty_in[15:8];  end
      3'b100:  begin own_cmd = cmd_in[5:4]; own_duty = duty_in[23:16]; end
      default: begin own_cmd = '0;          own_duty = '0;             end
    endcase
    if (own_duty > DUTY_MAX) own_duty = DUTY_MAX;
  end

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    grant_d   = grant_q;
    mask_d    = mask_eff;
    dead_d    = dead_q;
    hold_d    = hold_q;
    cmd_d     = '0;
    duty_d    = '0;
    timeout_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        grant_d = '0;
        if (win != 3'b000) begin
          pend_d  = win;
          dead_d  = DW'(1);
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        grant_d = '0;
        if (win != 3'b000 && (pend_q == 3'b000 || win < pend_q))
          pend_d = win;
        if (dead_q >= DEAD_LAST) begin
          if ((req & pend_d) != 3'b000) begin
            grant_d = pend_d;
            hold_d  = '0;
            state_d = ST_GRANTED;
          end else begin
            pend_d  = '0;
            state_d = ST_IDLE;
          end
        end else begin
          dead_d = dead_q + DW'(1);
        end
      end
      ST_GRANTED: begin
        if ((req & grant_q) == 3'b000) begin
          grant_d = '0;
          pend_d  = '0;
          state_d = ST_IDLE;
        end else if (PREEMPT && win != 3'b000 && win < grant_q) begin
          grant_d = '0;
          pend_d  = win;
          dead_d  = DW'(1);
          state_d = ST_GAP;
        end else if (tick && hold_q == HOLD_LAST) begin
          timeout_d = 1'b1;
          mask_d    = mask_eff | grant_q;
          grant_d   = '0;
          pend_d    = '0;
          state_d   = ST_IDLE;
        end else begin
          cmd_d  = own_cmd;
          duty_d = own_duty;
          if (tick && hold_q != HOLD_SAT) hold_d = hold_q + HW'(1);
        end
      end
      default: begin
        grant_d = '0;
        pend_d  = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      pend_q    <= '0;
      grant_q   <= '0;
      mask_q    <= '0;
      dead_q    <= '0;
      hold_q    <= '0;
      cmd_q     <= '0;
      duty_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      grant_q   <= grant_d;
      mask_q    <= mask_d;
      dead_q    <= dead_d;
      hold_q    <= hold_d;
      cmd_q     <= cmd_d;
      duty_q    <= duty_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant      = grant_q;
  assign motor_cmd  = cmd_q;
  assign motor_duty = duty_q;
  assign state      = state_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_motion_arbiter.sv
// Directed bench for motion_arbiter: one preempting and one non-preempting instance.
module tb_motion_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        tick = 1'b0;
  logic [2:0]  req_p = '0;
  logic [2:0]  req_n = '0;
  logic [5:0]  cmd_in = {2'b10, 2'b01, 2'b11};
  logic [23:0] duty_in = {8'd250, 8'd90, 8'd60};

  logic [2:0] grant_p, grant_n;
  logic [1:0] cmd_p, cmd_n;
  logic [7:0] duty_p, duty_n;
  logic [1:0] state_p, state_n;
  logic       to_p, to_n;

  int tests = 0;
  int fails = 0;
  int inv_tests = 0;
  int inv_fails = 0;

  always #5 clk = ~clk;

  motion_arbiter #(.DEAD_CYCLES(4), .MAX_HOLD_TICKS(10), .DUTY_MAX(8'd200), .PREEMPT(1'b1)) dut_p (
    .clk(clk), .reset_n(reset_n), .tick(tick), .req(req_p), .cmd_in(cmd_in), .duty_in(duty_in),
    .grant(grant_p), .motor_cmd(cmd_p), .motor_duty(duty_p), .state(state_p), .timeout(to_p)
  );

  motion_arbiter #(.DEAD_CYCLES(4), .MAX_HOLD_TICKS(10), .DUTY_MAX(8'd200), .PREEMPT(1'b0)) dut_n (
    .clk(clk), .reset_n(reset_n), .tick(tick), .req(req_n), .cmd_in(cmd_in), .duty_in(duty_in),
    .grant(grant_n), .motor_cmd(cmd_n), .motor_duty(duty_n), .state(state_n), .timeout(to_n)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // one-hot grant and STOP/0 whenever no owner or in the dead-time gap
  always @(negedge clk) begin
    if (reset_n) begin
      inv_tests++;
      assert ($onehot0(grant_p) && $onehot0(grant_n)
              && (grant_p != 3'b000 || (cmd_p == 2'b00 && duty_p == 8'd0))
              && (grant_n != 3'b000 || (cmd_n == 2'b00 && duty_n == 8'd0))
              && (state_p != 2'b01 || (grant_p == 3'b000 && cmd_p == 2'b00 && duty_p == 8'd0))
              && (state_n != 2'b01 || (grant_n == 3'b000 && cmd_n == 2'b00 && duty_n == 8'd0)))
      else begin
        inv_fails++;
        $error("FAIL invariant observed=%0h/%0h expected=onehot_and_stop", grant_p, grant_n);
      end
    end
  end

  initial begin
    // reset held with a pending request
    req_p = 3'b100;
    cyc(50);
    chk("rst_grant", 8'(grant_p), 8'h0);
    chk("rst_cmd", 8'(cmd_p), 8'h0);
    chk("rst_duty", duty_p, 8'h0);
    chk("rst_state", 8'(state_p), 8'h0);
    chk("rst_timeout", 8'(to_p), 8'h0);
    reset_n = 1'b1;
    cyc(1);
    chk("t1_gap_state", 8'(state_p), 8'h1);
    chk("t1_gap_grant", 8'(grant_p), 8'h0);
    cyc(3);
    chk("t1_gap_last", 8'(state_p), 8'h1);
    cyc(1);
    chk("t1_granted_state", 8'(state_p), 8'h2);
    chk("t1_grant", 8'(grant_p), 8'h4);
    chk("t1_cmd_latency", 8'(cmd_p), 8'h0);
    cyc(1);
    chk("t1_cmd", 8'(cmd_p), 8'h2);
    chk("t2_duty_clamp250", duty_p, 8'd200);
    duty_in[23:16] = 8'd37;
    cyc(1);
    chk("t2_duty37", duty_p, 8'd37);
    duty_in[23:16] = 8'd201;
    cyc(1);
    chk("t2_duty201", duty_p, 8'd200);
    duty_in[23:16] = 8'd200;
    cyc(1);
    chk("t2_duty200", duty_p, 8'd200);

    // preemption by requester 0
    req_p = 3'b101;
    cyc(1);
    chk("t3_pre_state", 8'(state_p), 8'h1);
    chk("t3_pre_grant", 8'(grant_p), 8'h0);
    chk("t3_pre_cmd", 8'(cmd_p), 8'h0);
    chk("t3_pre_duty", duty_p, 8'h0);
    cyc(3);
    chk("t3_pre_gap_end", 8'(grant_p), 8'h0);
    cyc(1);
    chk("t3_pre_grant0", 8'(grant_p), 8'h1);
    cyc(1);
    chk("t3_pre_cmd0", 8'(cmd_p), 8'h3);
    chk("t3_pre_duty0", duty_p, 8'd60);

    // owner 0 releases; requester 2 regains after a full gap
    req_p = 3'b100;
    cyc(1);
    chk("t4_rel_state", 8'(state_p), 8'h0);
    chk("t4_rel_grant", 8'(grant_p), 8'h0);
    cyc(1);
    chk("t4_rel_gap", 8'(state_p), 8'h1);
    cyc(4);
    chk("t4_regrant", 8'(grant_p), 8'h4);

    // hold timeout after 10 ticks
    for (int i = 0; i < 9; i++) begin
      tick = 1'b1; cyc(1); tick = 1'b0; cyc(1);
    end
    chk("t4_nine_ticks_grant", 8'(grant_p), 8'h4);
    chk("t4_nine_ticks_to", 8'(to_p), 8'h0);
    tick = 1'b1; cyc(1); tick = 1'b0;
    chk("t4_timeout", 8'(to_p), 8'h1);
    chk("t4_to_state", 8'(state_p), 8'h0);
    chk("t4_to_grant", 8'(grant_p), 8'h0);
    cyc(1);
    chk("t4_to_pulse_end", 8'(to_p), 8'h0);
    chk("t4_to_regap", 8'(state_p), 8'h1);
    cyc(4);
    chk("t4_to_regrant", 8'(grant_p), 8'h4);

    // request drop on the 10th tick wins over timeout
    for (int i = 0; i < 9; i++) begin
      tick = 1'b1; cyc(1); tick = 1'b0; cyc(1);
    end
    tick = 1'b1; req_p = 3'b000;
    cyc(1);
    tick = 1'b0;
    chk("t5_state", 8'(state_p), 8'h0);
    chk("t5_timeout", 8'(to_p), 8'h0);
    chk("t5_grant", 8'(grant_p), 8'h0);
    req_p = 3'b100;
    cyc(1);
    chk("t5_timeout_next", 8'(to_p), 8'h0);
    chk("t5_regap", 8'(state_p), 8'h1);
    cyc(4);
    chk("t5_regrant", 8'(grant_p), 8'h4);
    cyc(1);
    chk("t6_cmd_before", 8'(cmd_p), 8'h2);

    // asynchronous reset mid-GRANTED and mid-GAP
    #3 reset_n = 1'b0;
    #1;
    chk("t6_async_grant", 8'(grant_p), 8'h0);
    chk("t6_async_cmd", 8'(cmd_p), 8'h0);
    chk("t6_async_duty", duty_p, 8'h0);
    chk("t6_async_state", 8'(state_p), 8'h0);
    cyc(1);
    reset_n = 1'b1;
    cyc(1);
    chk("t6_restart_gap", 8'(state_p), 8'h1);
    cyc(2);
    #3 reset_n = 1'b0;
    #1;
    chk("t6_gap_reset_state", 8'(state_p), 8'h0);
    chk("t6_gap_reset_grant", 8'(grant_p), 8'h0);
    cyc(1);
    reset_n = 1'b1;
    req_p = 3'b000;
    cyc(2);

    // non-preempting instance keeps the owner
    req_n = 3'b100;
    cyc(1);
    chk("n3_gap", 8'(state_n), 8'h1);
    cyc(4);
    chk("n3_grant2", 8'(grant_n), 8'h4);
    req_n = 3'b101;
    cyc(5);
    chk("n3_keep_grant", 8'(grant_n), 8'h4);
    chk("n3_keep_state", 8'(state_n), 8'h2);
    req_n = 3'b001;
    cyc(1);
    chk("n3_drop_idle", 8'(state_n), 8'h0);
    cyc(1);
    chk("n3_drop_gap", 8'(state_n), 8'h1);
    cyc(4);
    chk("n3_grant0", 8'(grant_n), 8'h1);

    // timeout hands the drive to requester 1, requester 2 masked
    req_n = 3'b100;
    cyc(2);
    cyc(4);
    chk("n4_grant2", 8'(grant_n), 8'h4);
    req_n = 3'b110;
    cyc(1);
    chk("n4_hold_with_req1", 8'(grant_n), 8'h4);
    for (int i = 0; i < 10; i++) begin
      tick = 1'b1; cyc(1); tick = 1'b0;
      if (i < 9) cyc(1);
    end
    chk("n4_timeout", 8'(to_n), 8'h1);
    chk("n4_to_grant", 8'(grant_n), 8'h0);
    cyc(1);
    chk("n4_gap", 8'(state_n), 8'h1);
    cyc(4);
    chk("n4_grant1", 8'(grant_n), 8'h2);
    cyc(1);
    chk("n4_cmd1", 8'(cmd_n), 8'h1);
    chk("n4_duty1", duty_n, 8'd90);
    req_n = 3'b100;
    cyc(1);
    chk("n4_rel_idle", 8'(state_n), 8'h0);
    cyc(1);
    chk("n4_mask_clear_gap", 8'(state_n), 8'h1);
    cyc(4);
    chk("n4_masked_regrant", 8'(grant_n), 8'h4);
    req_n = 3'b000;
    cyc(2);

    tests += inv_tests;
    fails += inv_fails;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
